// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined borrow-lookahead subtractor (diff = a + ~b + ~bin) with valid/ready flow control and flags.
// Define CLA_SUB_SAT_EN to saturate out_diff on signed overflow; otherwise the wrapped difference is emitted.
module cla_sub_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
);

  localparam int H  = WIDTH / 2;
  localparam int NG = H / 4;

  // Half-width adder: 4-bit group P/G, group and bit carries both expanded as lookahead sums of products.
  function automatic logic [H:0] cla_half(input logic [H-1:0] x, input logic [H-1:0] y, input logic cin);
    logic [H-1:0]  p;
    logic [H-1:0]  g;
    logic [H-1:0]  s;
    logic [NG-1:0] gp;
    logic [NG-1:0] gg;
    logic [NG:0]   gc;
    logic          c;
    logic          run;
    p = x ^ y;
    g = x & y;
    for (int k = 0; k < NG; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    gc[0] = cin;
    for (int k = 0; k < NG; k++) begin
      c   = 1'b0;
      run = 1'b1;
      for (int j = k; j >= 0; j--) begin
        c   = c | (run & gg[j]);
        run = run & gp[j];
      end
      gc[k+1] = c | (run & cin);
    end
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < 4; i++) begin
        c   = 1'b0;
        run = 1'b1;
        for (int m = i - 1; m >= 0; m--) begin
          c   = c | (run & g[4*k+m]);
          run = run & p[4*k+m];
        end
        c = c | (run & gc[k]);
        s[4*k+i] = p[4*k+i] ^ c;
      end
    end
    return {gc[NG], s};
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [H-1:0]     s1_lo_q, s1_lo_d;
  logic             s1_c_q, s1_c_d;
  logic [H-1:0]     s1_ahi_q, s1_ahi_d;
  logic [H-1:0]     s1_nbhi_q, s1_nbhi_d;
  logic             s1_asign_q, s1_asign_d;
  logic             s1_bsign_q, s1_bsign_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_diff_q, out_diff_d;
  logic             out_borrow_q, out_borrow_d;
  logic             out_zero_q, out_zero_d;
  logic             out_neg_q, out_neg_d;
  logic             out_ovf_q, out_ovf_d;

  logic             s1_adv, s2_adv;
  logic [H:0]       lo_sum, hi_sum;
  logic [WIDTH-1:0] raw_diff, fin_diff;
  logic             raw_ovf;

  always_comb begin
    s2_adv = !out_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;

    lo_sum   = cla_half(in_a[H-1:0], ~in_b[H-1:0], ~in_bin);
    hi_sum   = cla_half(s1_ahi_q, s1_nbhi_q, s1_c_q);
    raw_diff = {hi_sum[H-1:0], s1_lo_q};
    raw_ovf  = (s1_asign_q != s1_bsign_q) && (raw_diff[WIDTH-1] != s1_asign_q);
    fin_diff = raw_diff;
`ifdef CLA_SUB_SAT_EN
    if (raw_ovf) begin
      fin_diff = s1_asign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif

    s1_valid_d   = s1_valid_q;
    s1_lo_d      = s1_lo_q;
    s1_c_d       = s1_c_q;
    s1_ahi_d     = s1_ahi_q;
    s1_nbhi_d    = s1_nbhi_q;
    s1_asign_d   = s1_asign_q;
    s1_bsign_d   = s1_bsign_q;
    out_valid_d  = out_valid_q;
    out_diff_d   = out_diff_q;
    out_borrow_d = out_borrow_q;
    out_zero_d   = out_zero_q;
    out_neg_d    = out_neg_q;
    out_ovf_d    = out_ovf_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
    end
    if (s1_adv && in_valid) begin
      s1_lo_d    = lo_sum[H-1:0];
      s1_c_d     = lo_sum[H];
      s1_ahi_d   = in_a[WIDTH-1:H];
      s1_nbhi_d  = ~in_b[WIDTH-1:H];
      s1_asign_d = in_a[WIDTH-1];
      s1_bsign_d = in_b[WIDTH-1];
    end

    // Output data only moves when a beat actually advances, so held results stay stable.
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
    end
    if (s2_adv && s1_valid_q) begin
      out_diff_d   = fin_diff;
      out_borrow_d = ~hi_sum[H];
      out_zero_d   = (fin_diff == '0);
      out_neg_d    = fin_diff[WIDTH-1];
      out_ovf_d    = raw_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_lo_q      <= '0;
      s1_c_q       <= 1'b0;
      s1_ahi_q     <= '0;
      s1_nbhi_q    <= '0;
      s1_asign_q   <= 1'b0;
      s1_bsign_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_diff_q   <= '0;
      out_borrow_q <= 1'b0;
      out_zero_q   <= 1'b0;
      out_neg_q    <= 1'b0;
      out_ovf_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_lo_q      <= s1_lo_d;
      s1_c_q       <= s1_c_d;
      s1_ahi_q     <= s1_ahi_d;
      s1_nbhi_q    <= s1_nbhi_d;
      s1_asign_q   <= s1_asign_d;
      s1_bsign_q   <= s1_bsign_d;
      out_valid_q  <= out_valid_d;
      out_diff_q   <= out_diff_d;
      out_borrow_q <= out_borrow_d;
      out_zero_q   <= out_zero_d;
      out_neg_q    <= out_neg_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  assign in_ready   = s1_adv;
  assign out_valid  = out_valid_q;
  assign out_diff   = out_diff_q;
  assign out_borrow = out_borrow_q;
  assign out_zero   = out_zero_q;
  assign out_neg    = out_neg_q;
  assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Randomized and directed bench for cla_sub_pipe, scoreboarded against an arithmetic reference model.
// Honours CLA_SUB_SAT_EN the same way the design does.
module tb_cla_sub_pipe;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] diff;
    logic [3:0]   flags;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_diff;
  logic         out_borrow;
  logic         out_zero;
  logic         out_neg;
  logic         out_ovf;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  logic last_accept;
  logic rand_ready = 1'b0;
  exp_t exp_q[$];

  cla_sub_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_borrow(out_borrow),
    .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: plain wide subtraction; overflow from the operand/result sign rule.
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic bin);
    logic [W:0]   wide;
    logic [W-1:0] raw;
    logic [W-1:0] d;
    logic         ovf;
    exp_t         e;
    wide = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    raw  = wide[W-1:0];
    ovf  = (a[W-1] != b[W-1]) && (raw[W-1] != a[W-1]);
    d    = raw;
`ifdef CLA_SUB_SAT_EN
    if (ovf) d = a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    e.diff  = d;
    e.flags = {wide[W], (d == 0), d[W-1], ovf};
    return e;
  endfunction

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0001_0000 + $urandom_range(0, 3) - 2;
      5:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // One clock: score the output beat and the input accept as seen just before the edge.
  task automatic tick();
    exp_t e;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    last_accept = in_valid && in_ready;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_out", {63'd0, out_valid}, 64'd0);
      end else begin
        e = exp_q[0];
        checkOutput("diff", {32'd0, out_diff}, {32'd0, e.diff});
        checkOutput("flags", {60'd0, out_borrow, out_zero, out_neg, out_ovf}, {60'd0, e.flags});
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
    end
    if (last_accept) exp_q.push_back(model(in_a, in_b, in_bin));
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(logic [W-1:0] a, logic [W-1:0] b, logic bin);
    logic accepted;
    accepted = 1'b0;
    in_a     = a;
    in_b     = b;
    in_bin   = bin;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      tick();
      accepted = last_accept;
    end
    checkOutput("accept", {63'd0, accepted}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drainOut();
    in_valid = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    checkOutput("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic runDirected(string tag, logic [W-1:0] a, logic [W-1:0] b, logic bin,
                             logic [W-1:0] exp_diff, logic [3:0] exp_flags);
    out_ready = 1'b1;
    applyStimulus(a, b, bin);
    tick();
    checkOutput({tag, "_latency"}, {63'd0, out_valid}, 64'd1);
    checkOutput({tag, "_diff"}, {32'd0, out_diff}, {32'd0, exp_diff});
    checkOutput({tag, "_flags"}, {60'd0, out_borrow, out_zero, out_neg, out_ovf}, {60'd0, exp_flags});
    tick();
  endtask

  task automatic checkIdleOutputs(string tag);
    checkOutput({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    checkOutput({tag, "_outs"}, {28'd0, out_diff, out_borrow, out_zero, out_neg, out_ovf}, 64'd0);
    checkOutput({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_bin = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    rst = 1'b0;

    // Flags order: borrow, zero, neg, ovf
    runDirected("basic",   32'd5, 32'd3, 1'b0, 32'h0000_0002, 4'b0000);
    runDirected("neg",     32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE, 4'b1010);
    runDirected("eq",      32'd7, 32'd7, 1'b0, 32'h0000_0000, 4'b0100);
    runDirected("eq_bin",  32'd7, 32'd7, 1'b1, 32'hFFFF_FFFF, 4'b1010);
`ifdef CLA_SUB_SAT_EN
    runDirected("ovf",     32'h8000_0000, 32'd1, 1'b0, 32'h8000_0000, 4'b0011);
`else
    runDirected("ovf",     32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 4'b0001);
`endif
    runDirected("halfcy",  32'h0001_0000, 32'd1, 1'b0, 32'h0000_FFFF, 4'b0000);
    runDirected("ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 4'b0100);
    runDirected("bzero",   32'h1234_5678, 32'd0, 1'b0, 32'h1234_5678, 4'b0000);

    // Backpressure: two beats fill the pipe while the consumer stalls.
    base = n_out;
    out_ready = 1'b0;
    applyStimulus(32'd100, 32'd1, 1'b0);
    applyStimulus(32'd200, 32'd2, 1'b1);
    in_a = 32'd300; in_b = 32'd3; in_bin = 1'b0; in_valid = 1'b1;
    #1;
    checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    tick();
    checkOutput("bp_hold_accept", {63'd0, last_accept}, 64'd0);
    out_ready = 1'b1;
    applyStimulus(32'd300, 32'd3, 1'b0);
    applyStimulus(32'd5, 32'd400, 1'b1);
    drainOut();
    checkOutput("bp_count", 64'(n_out - base), 64'd4);

    // Random traffic with random consumer backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(pickOperand(), pickOperand(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drainOut();

    // Reset with two beats held in the pipe; they must vanish.
    out_ready = 1'b0;
    applyStimulus(32'd9, 32'd4, 1'b0);
    applyStimulus(32'd11, 32'd4, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    checkIdleOutputs("midrst");
    out_ready = 1'b1;
    repeat (6) tick();
    checkOutput("flush_no_out", {63'd0, out_valid}, 64'd0);
    runDirected("post_rst", 32'd10, 32'd4, 1'b0, 32'h0000_0006, 4'b0000);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
